hazard_scoreboard: RTL and testbench

//  Scoreboard-based hazard controller for the 5-stage MIPS pipeline. Consumes the per-instruction

---
 rtl/hazard_scoreboard.sv | 98 +++++++++
 tb/tb_hazard_scoreboard.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard controller for the 5-stage MIPS pipeline: tracks in-flight register
// writes through E/M/W and produces the D-stage stall plus rs/rt forwarding selects.
module hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic             use_rs_D,
  input  logic             use_rt_D,
  input  logic [1:0]       Tuse_rs_D,
  input  logic [1:0]       Tuse_rt_D,
  input  logic [4:0]       WAG_D,
  input  logic             RegWrite_D,
  input  logic [1:0]       Tnew_D,
  input  logic             ext_stall,
  output logic             stall,
  output logic [1:0]       fwd_rs,
  output logic [1:0]       fwd_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  // Storage covers the full 5-bit register space; slots at or above NREG never become valid.
  localparam int         NSLOT  = 32;
  localparam logic [1:0] AGE_E  = 2'd1;
  localparam logic [1:0] AGE_W  = 2'd3;

  logic [NSLOT-1:0] valid_q;
  logic [1:0]       age_q  [NSLOT];
  logic [1:0]       tnew_q [NSLOT];

  logic hazard_rs;
  logic hazard_rt;
  logic issue;

  function automatic logic tracked(input logic [4:0] r);
    return (r != 5'd0) && (int'(r) < NREG);
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    hazard_rs = 1'b0;
    hazard_rt = 1'b0;
    fwd_rs    = 2'b00;
    fwd_rt    = 2'b00;
    if (use_rs_D && tracked(rs_D) && valid_q[rs_D]) begin
      hazard_rs = (tnew_q[rs_D] > Tuse_rs_D);
      if (tnew_q[rs_D] == 2'd0) fwd_rs = age_q[rs_D];
    end
    if (use_rt_D && tracked(rt_D) && valid_q[rt_D]) begin
      hazard_rt = (tnew_q[rt_D] > Tuse_rt_D);
      if (tnew_q[rt_D] == 2'd0) fwd_rt = age_q[rt_D];
    end
    stall = hazard_rs | hazard_rt | ext_stall;
    issue = !stall && RegWrite_D && tracked(WAG_D);
  end

  // Entries age every cycle regardless of stall; a stalled D simply issues nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      stall_cnt <= '0;
      for (int r = 0; r < NSLOT; r++) begin
        age_q[r]  <= 2'd0;
        tnew_q[r] <= 2'd0;
      end
    end else begin
      for (int r = 0; r < NSLOT; r++) begin
        if (valid_q[r]) begin
          if (age_q[r] == AGE_W) begin
            valid_q[r] <= 1'b0;
            age_q[r]   <= 2'd0;
          end else begin
            age_q[r] <= age_q[r] + 2'd1;
          end
          tnew_q[r] <= sat_dec2(tnew_q[r]);
        end
      end
      // Placed after the advance loop so the newest writer overrides its slot's retire/advance.
      if (issue) begin
        valid_q[WAG_D] <= 1'b1;
        age_q[WAG_D]   <= AGE_E;
        tnew_q[WAG_D]  <= Tnew_D;
      end
      if (stall) stall_cnt <= sat_inc_cnt(stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus randomized traffic checked
// against a timestamp model (last issue cycle per register) of the in-flight writes.
module tb_hazard_scoreboard;

  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       rs_D, rt_D, WAG_D;
  logic             use_rs_D, use_rt_D, RegWrite_D, ext_stall;
  logic [1:0]       Tuse_rs_D, Tuse_rt_D, Tnew_D;
  logic             stall;
  logic [1:0]       fwd_rs, fwd_rt;
  logic [CNT_W-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  // Model: cycle count since reset, issue cycle and Tnew of the latest writer of each register.
  int cyc;
  int last_iss [32];
  int last_tn  [32];
  int cnt;

  hazard_scoreboard #(.NREG(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
    .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
    .WAG_D(WAG_D), .RegWrite_D(RegWrite_D), .Tnew_D(Tnew_D), .ext_stall(ext_stall),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // A writer issued at cycle k is in E at cycle k (age 1) and forwardable once Tnew-(age-1) hits 0.
  function automatic void model_src(input logic u, input logic [4:0] s, input logic [1:0] tuse,
                                    output logic haz, output logic [1:0] fw);
    int age;
    int tn;
    haz = 1'b0;
    fw  = 2'b00;
    if (u && s != 5'd0 && last_iss[s] >= 0) begin
      age = cyc - last_iss[s] + 1;
      if (age <= 3) begin
        tn = last_tn[s] - (age - 1);
        if (tn < 0) tn = 0;
        haz = (tn > int'(tuse));
        if (tn == 0) fw = age[1:0];
      end
    end
  endfunction

  function automatic logic model_stall();
    logic hr, ht;
    logic [1:0] fr, ft;
    model_src(use_rs_D, rs_D, Tuse_rs_D, hr, fr);
    model_src(use_rt_D, rt_D, Tuse_rt_D, ht, ft);
    return hr | ht | ext_stall;
  endfunction

  task automatic eval_comb(input string tag);
    logic hr, ht;
    logic [1:0] fr, ft;
    #2;
    model_src(use_rs_D, rs_D, Tuse_rs_D, hr, fr);
    model_src(use_rt_D, rt_D, Tuse_rt_D, ht, ft);
    chk({tag, ".stall"}, stall, hr | ht | ext_stall);
    chk({tag, ".fwd_rs"}, fwd_rs, fr);
    chk({tag, ".fwd_rt"}, fwd_rt, ft);
  endtask

  task automatic tick();
    logic ms;
    ms = model_stall();
    @(posedge clk);
    if (reset) begin
      cyc = 0;
      cnt = 0;
      for (int r = 0; r < 32; r++) last_iss[r] = -1;
    end else begin
      if (ms && cnt < CNT_MAX) cnt++;
      cyc++;
      if (!ms && RegWrite_D && WAG_D != 5'd0) begin
        last_iss[WAG_D] = cyc;
        last_tn[WAG_D]  = int'(Tnew_D);
      end
    end
    #1;
    chk("stall_cnt_model", stall_cnt, cnt);
  endtask

  task automatic set_d(input logic [4:0] rs, input logic urs, input logic [1:0] trs,
                       input logic [4:0] rt, input logic urt, input logic [1:0] trt,
                       input logic [4:0] wag, input logic rw, input logic [1:0] tn);
    rs_D = rs; use_rs_D = urs; Tuse_rs_D = trs;
    rt_D = rt; use_rt_D = urt; Tuse_rt_D = trt;
    WAG_D = wag; RegWrite_D = rw; Tnew_D = tn;
  endtask

  task automatic idle();
    set_d(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0);
    ext_stall = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    cyc = 0;
    cnt = 0;
    for (int r = 0; r < 32; r++) begin
      last_iss[r] = -1;
      last_tn[r]  = 0;
    end
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    eval_comb("rst");
    chk("rst.stall", stall, 1'b0);
    chk("rst.fwd_rs", fwd_rs, 2'b00);
    chk("rst.cnt", stall_cnt, 0);

    // ALU -> ALU: producer in E not yet forwardable, then M, then W, then retired
    set_d(5'd1, 1'b0, 2'd1, 5'd2, 1'b0, 2'd1, 5'd8, 1'b1, 2'd1);
    eval_comb("t1.issue");
    tick();
    set_d(5'd8, 1'b1, 2'd1, 5'd8, 1'b1, 2'd1, 5'd0, 1'b0, 2'd1);
    eval_comb("t1.e");
    chk("t1.e.stall", stall, 1'b0);
    chk("t1.e.fwd_rs", fwd_rs, 2'b00);
    tick();
    eval_comb("t1.m");
    chk("t1.m.fwd_rs", fwd_rs, 2'b10);
    chk("t1.m.fwd_rt", fwd_rt, 2'b10);
    tick();
    eval_comb("t1.w");
    chk("t1.w.fwd_rs", fwd_rs, 2'b11);
    tick();
    eval_comb("t1.rf");
    chk("t1.rf.fwd_rs", fwd_rs, 2'b00);

    // Load-use: one stall cycle
    do_reset();
    set_d(5'd0, 1'b0, 2'd1, 5'd0, 1'b0, 2'd1, 5'd9, 1'b1, 2'd2);
    tick();
    set_d(5'd9, 1'b1, 2'd1, 5'd0, 1'b1, 2'd1, 5'd10, 1'b1, 2'd1);
    eval_comb("t2.s1");
    chk("t2.s1.stall", stall, 1'b1);
    tick();
    eval_comb("t2.go");
    chk("t2.go.stall", stall, 1'b0);
    chk("t2.go.fwd_rs", fwd_rs, 2'b00);
    chk("t2.cnt", stall_cnt, 1);
    tick();

    // Load -> beq: two stall cycles, then W forward
    do_reset();
    set_d(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd9, 1'b1, 2'd2);
    tick();
    set_d(5'd9, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0);
    eval_comb("t3.s1");
    chk("t3.s1.stall", stall, 1'b1);
    tick();
    eval_comb("t3.s2");
    chk("t3.s2.stall", stall, 1'b1);
    tick();
    eval_comb("t3.go");
    chk("t3.go.stall", stall, 1'b0);
    chk("t3.go.fwd_rs", fwd_rs, 2'b11);
    chk("t3.cnt", stall_cnt, 2);

    // Newest writer wins
    do_reset();
    set_d(5'd0, 1'b0, 2'd1, 5'd0, 1'b0, 2'd1, 5'd5, 1'b1, 2'd1);
    tick();
    set_d(5'd1, 1'b1, 2'd1, 5'd2, 1'b1, 2'd1, 5'd5, 1'b1, 2'd1);
    tick();
    set_d(5'd5, 1'b1, 2'd1, 5'd0, 1'b0, 2'd1, 5'd0, 1'b0, 2'd1);
    eval_comb("t4.e");
    chk("t4.e.fwd_rs", fwd_rs, 2'b00);
    tick();
    eval_comb("t4.m");
    chk("t4.m.fwd_rs", fwd_rs, 2'b10);

    // $0 never tracked; a Tnew=0 write forwards from E, then retires after W
    do_reset();
    set_d(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b1, 2'd2);
    tick();
    set_d(5'd0, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0, 5'd3, 1'b1, 2'd0);
    eval_comb("t5.r0");
    chk("t5.r0.stall", stall, 1'b0);
    chk("t5.r0.fwd_rs", fwd_rs, 2'b00);
    tick();
    set_d(5'd3, 1'b1, 2'd0, 5'd3, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0);
    eval_comb("t5.e");
    chk("t5.e.fwd_rs", fwd_rs, 2'b01);
    chk("t5.e.fwd_rt", fwd_rt, 2'b01);
    tick();
    tick();
    tick();
    eval_comb("t5.rf");
    chk("t5.rf.fwd_rs", fwd_rs, 2'b00);

    // Reset during a load-use stall; then ext_stall blocks issue
    do_reset();
    set_d(5'd0, 1'b0, 2'd1, 5'd0, 1'b0, 2'd1, 5'd9, 1'b1, 2'd2);
    tick();
    set_d(5'd9, 1'b1, 2'd1, 5'd0, 1'b0, 2'd1, 5'd10, 1'b1, 2'd1);
    eval_comb("t6.s");
    chk("t6.s.stall", stall, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    eval_comb("t6.after");
    chk("t6.after.stall", stall, 1'b0);
    chk("t6.after.fwd_rs", fwd_rs, 2'b00);
    chk("t6.after.cnt", stall_cnt, 0);
    set_d(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd7, 1'b1, 2'd1);
    ext_stall = 1'b1;
    eval_comb("t6.ext");
    chk("t6.ext.stall", stall, 1'b1);
    tick();
    ext_stall = 1'b0;
    set_d(5'd7, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0);
    eval_comb("t6.noissue");
    chk("t6.noissue.stall", stall, 1'b0);
    chk("t6.cnt", stall_cnt, 1);

    // Counter saturation
    idle();
    ext_stall = 1'b1;
    for (int i = 0; i < CNT_MAX + 8; i++) tick();
    chk("sat.cnt", stall_cnt, CNT_MAX);
    do_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      reset      = (i < 400) && ($urandom_range(0, 99) < 2);
      rs_D       = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      rt_D       = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      use_rs_D   = 1'($urandom_range(0, 1));
      use_rt_D   = 1'($urandom_range(0, 1));
      Tuse_rs_D  = 2'($urandom_range(0, 2));
      Tuse_rt_D  = 2'($urandom_range(0, 2));
      WAG_D      = 5'($urandom_range(0, 5));
      RegWrite_D = ($urandom_range(0, 3) != 0);
      Tnew_D     = 2'($urandom_range(0, 2));
      ext_stall  = ($urandom_range(0, 9) == 0);
      eval_comb("rand");
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
